// File: rtl/lmem_arbiter_if.sv
// Signal bundle for the shared layer-memory port: requester-side request/return
// fields plus the registered memory command bus and its read-data return.
interface lmem_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int AW    = 12,
    parameter int DW    = 20,
    parameter int SW    = 3
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    we;
    logic [N_REQ-1:0]    lock;
    logic [N_REQ*SW-1:0] sel;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [DW-1:0]       rdata;
    logic [SW-1:0]       csel;
    logic                cwr;
    logic [AW-1:0]       caddr_wr;
    logic [DW-1:0]       cdata_wr;
    logic                crd;
    logic [AW-1:0]       caddr_rd;
    logic [DW-1:0]       cdata_rd;
    logic                busy;

    modport slave (
        input  req, we, lock, sel, addr, wdata, cdata_rd,
        output gnt, rvalid, rdata, csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd, busy
    );

    modport master (
        output req, we, lock, sel, addr, wdata, cdata_rd,
        input  gnt, rvalid, rdata, csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd, busy
    );
endinterface

// File: rtl/lmem_arbiter.sv
// Round-robin arbiter with burst lock for the shared layer-memory port; issues
// registered read/write commands and returns read data tagged to its requester.
module lmem_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 12,
    parameter int DW    = 20,
    parameter int SW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    lmem_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef logic [IW-1:0] idx_t;

    idx_t             rr_ptr_r;
    idx_t             owner_r;
    logic             owner_vld_r;
    idx_t             gnt_idx_s;
    logic             gnt_any_s;
    idx_t             cand_s;
    logic             rd1_vld_r;
    logic             rd2_vld_r;
    idx_t             rd1_idx_r;
    idx_t             rd2_idx_r;
    logic [SW-1:0]    csel_r;
    logic             cwr_r;
    logic             crd_r;
    logic [AW-1:0]    caddr_wr_r;
    logic [AW-1:0]    caddr_rd_r;
    logic [DW-1:0]    cdata_wr_r;
    logic [N_REQ-1:0] rvalid_r;
    logic [DW-1:0]    rdata_r;

    function automatic logic [N_REQ-1:0] onehot(input idx_t i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // The lock owner has exclusive use of the port, idle or not; otherwise
    // the first requester at or after rr_ptr wins.
    always_comb begin
        gnt_idx_s = rr_ptr_r;
        gnt_any_s = 1'b0;
        cand_s    = rr_ptr_r;
        if (owner_vld_r) begin
            gnt_idx_s = owner_r;
            gnt_any_s = bus.req[owner_r];
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                cand_s = (int'(rr_ptr_r) + k >= N_REQ) ? idx_t'(int'(rr_ptr_r) + k - N_REQ)
                                                       : idx_t'(int'(rr_ptr_r) + k);
                if (!gnt_any_s && bus.req[cand_s]) begin
                    gnt_any_s = 1'b1;
                    gnt_idx_s = cand_s;
                end else begin
                    gnt_any_s = gnt_any_s;
                end
            end
        end
    end

    // Arbitration state, memory command registers and the two-stage read tag pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r    <= idx_t'(0);
            owner_r     <= idx_t'(0);
            owner_vld_r <= 1'b0;
            rd1_vld_r   <= 1'b0;
            rd2_vld_r   <= 1'b0;
            rd1_idx_r   <= idx_t'(0);
            rd2_idx_r   <= idx_t'(0);
            csel_r      <= '0;
            cwr_r       <= 1'b0;
            crd_r       <= 1'b0;
            caddr_wr_r  <= '0;
            caddr_rd_r  <= '0;
            cdata_wr_r  <= '0;
            rvalid_r    <= '0;
            rdata_r     <= '0;
        end else begin
            cwr_r     <= 1'b0;
            crd_r     <= 1'b0;
            rd1_vld_r <= 1'b0;
            if (gnt_any_s) begin
                csel_r    <= bus.sel[gnt_idx_s*SW +: SW];
                rd1_idx_r <= gnt_idx_s;
                if (bus.we[gnt_idx_s]) begin
                    cwr_r      <= 1'b1;
                    caddr_wr_r <= bus.addr[gnt_idx_s*AW +: AW];
                    cdata_wr_r <= bus.wdata[gnt_idx_s*DW +: DW];
                end else begin
                    crd_r      <= 1'b1;
                    caddr_rd_r <= bus.addr[gnt_idx_s*AW +: AW];
                    rd1_vld_r  <= 1'b1;
                end
                owner_r     <= gnt_idx_s;
                owner_vld_r <= bus.lock[gnt_idx_s];
                // Locked grants leave the pointer alone; the releasing grant advances it.
                if (!bus.lock[gnt_idx_s]) begin
                    rr_ptr_r <= (gnt_idx_s == idx_t'(N_REQ - 1)) ? idx_t'(0)
                                                                 : idx_t'(gnt_idx_s + 1'b1);
                end else begin
                    rr_ptr_r <= rr_ptr_r;
                end
            end else begin
                owner_vld_r <= 1'b0;
            end
            rd2_vld_r <= rd1_vld_r;
            rd2_idx_r <= rd1_idx_r;
            rvalid_r  <= rd2_vld_r ? onehot(rd2_idx_r) : '0;
            rdata_r   <= rd2_vld_r ? bus.cdata_rd : '0;
        end
    end

    assign bus.gnt      = (gnt_any_s && !reset) ? onehot(gnt_idx_s) : '0;
    assign bus.busy     = !reset && ((|bus.req) || cwr_r || crd_r || rd1_vld_r || rd2_vld_r);
    assign bus.csel     = csel_r;
    assign bus.cwr      = cwr_r;
    assign bus.crd      = crd_r;
    assign bus.caddr_wr = caddr_wr_r;
    assign bus.caddr_rd = caddr_rd_r;
    assign bus.cdata_wr = cdata_wr_r;
    assign bus.rvalid   = rvalid_r;
    assign bus.rdata    = rdata_r;
endmodule

// File: tb/tb_lmem_arbiter.sv
// Bench for lmem_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_lmem_arbiter;
    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 20;
    localparam int SW = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    lmem_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW), .SW(SW)) bus ();
    lmem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .SW(SW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [N-1:0] last_gnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic bitof(input logic [31:0] v, input int i);
        logic [4:0] b;
        b = 5'(i);
        return v[b];
    endfunction

    // Contents of never-written memory locations
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 12'h041) ? 20'h0ABCD : {8'h5A, a};
    endfunction

    // Layer memory: write lands at the end of the cwr cycle, read data the cycle after crd
    logic [DW-1:0] mem [0:4095];
    bit            written [0:4095];
    always @(posedge clk) begin
        if (bus.cwr) begin
            mem[bus.caddr_wr]     <= bus.cdata_wr;
            written[bus.caddr_wr] <= 1'b1;
        end
        if (bus.crd)
            bus.cdata_rd <= written[bus.caddr_rd] ? mem[bus.caddr_rd] : init_val(bus.caddr_rd);
    end

    // Reference model state: pointer, owner, last issued command, outstanding reads
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } rd_t;
    rd_t           pq[$];
    logic [DW-1:0] sh [0:4095];
    bit            sh_w [0:4095];
    int            m_rr    = 0;
    int            m_owner = -1;
    logic          e_cwr   = 1'b0;
    logic          e_crd   = 1'b0;
    logic [SW-1:0] e_csel  = '0;
    logic [AW-1:0] e_cwa   = '0;
    logic [AW-1:0] e_cra   = '0;
    logic [DW-1:0] e_cwd   = '0;
    logic [N-1:0]  eg, erv;
    logic [DW-1:0] erd, gd;
    logic [AW-1:0] ga;
    logic          eb;
    int            g;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_gnt", 32'(bus.gnt), 32'd0);
            chk("rst_cwr", 32'(bus.cwr), 32'd0);
            chk("rst_crd", 32'(bus.crd), 32'd0);
            chk("rst_csel", 32'(bus.csel), 32'd0);
            chk("rst_caddr_wr", 32'(bus.caddr_wr), 32'd0);
            chk("rst_caddr_rd", 32'(bus.caddr_rd), 32'd0);
            chk("rst_cdata_wr", 32'(bus.cdata_wr), 32'd0);
            chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
            chk("rst_rdata", 32'(bus.rdata), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            m_rr = 0; m_owner = -1;
            e_cwr = 1'b0; e_crd = 1'b0; e_csel = '0; e_cwa = '0; e_cra = '0; e_cwd = '0;
            pq.delete();
            last_gnt = '0;
        end else begin
            g = -1;
            if (m_owner >= 0) begin
                if (bitof(32'(bus.req), m_owner)) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && bitof(32'(bus.req), (m_rr + k) % N)) g = (m_rr + k) % N;
            end
            eg  = (g >= 0) ? (N'(1'b1) << g) : '0;
            erv = '0;
            erd = '0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                erv = N'(1'b1) << pq[0].idx;
                erd = pq[0].data;
                void'(pq.pop_front());
            end
            eb = (|bus.req) || e_cwr || e_crd || (pq.size() > 0);

            chk("gnt", 32'(bus.gnt), 32'(eg));
            chk("cwr", 32'(bus.cwr), 32'(e_cwr));
            chk("crd", 32'(bus.crd), 32'(e_crd));
            chk("cwr_crd_excl", 32'(bus.cwr & bus.crd), 32'd0);
            chk("csel", 32'(bus.csel), 32'(e_csel));
            chk("caddr_wr", 32'(bus.caddr_wr), 32'(e_cwa));
            chk("cdata_wr", 32'(bus.cdata_wr), 32'(e_cwd));
            chk("caddr_rd", 32'(bus.caddr_rd), 32'(e_cra));
            chk("rvalid", 32'(bus.rvalid), 32'(erv));
            chk("rdata", 32'(bus.rdata), 32'(erd));
            chk("busy", 32'(bus.busy), 32'(eb));

            last_gnt = eg;
            if (g >= 0) begin
                ga = AW'(bus.addr >> (g * AW));
                gd = DW'(bus.wdata >> (g * DW));
                e_csel = SW'(bus.sel >> (g * SW));
                if (bitof(32'(bus.we), g)) begin
                    e_cwr = 1'b1; e_crd = 1'b0; e_cwa = ga; e_cwd = gd;
                    sh[ga] = gd; sh_w[ga] = 1'b1;
                end else begin
                    e_crd = 1'b1; e_cwr = 1'b0; e_cra = ga;
                    pq.push_back('{due: cyc + 3, idx: g, data: sh_w[ga] ? sh[ga] : init_val(ga)});
                end
                if (bitof(32'(bus.lock), g)) begin
                    m_owner = g;
                end else begin
                    m_owner = -1;
                    m_rr    = (g + 1) % N;
                end
            end else begin
                e_cwr = 1'b0; e_crd = 1'b0; m_owner = -1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int i, input logic r, input logic w, input logic l,
                          input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [1:0] ii;
        ii = 2'(i);
        bus.req[ii]  = r;
        bus.we[ii]   = w;
        bus.lock[ii] = l;
        bus.sel[i*SW +: SW]   = s;
        bus.addr[i*AW +: AW]  = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    logic [N-1:0]  rr_exp [6];
    logic [AW-1:0] lock_addr [4];

    initial begin
        rr_exp    = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        lock_addr = '{12'd0, 12'd1, 12'd64, 12'd65};
        bus.req = '0; bus.we = '0; bus.lock = '0;
        bus.sel = '0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Round-robin with every requester reading continuously
        step();
        bus.req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(bus.gnt), 32'(rr_exp[k]));
            if (k > 0) chk("rr_cmd", 32'(bus.crd), 32'd1);
            step();
        end
        bus.req = '0;
        repeat (4) step();

        // Single read from requester 1
        set_rq(1, 1'b1, 1'b0, 1'b0, 3'b001, 12'h041, 20'h0);
        @(negedge clk);
        chk("sr_gnt", 32'(bus.gnt), 32'h2);
        step();
        bus.req = '0;
        @(negedge clk);
        chk("sr_crd", 32'(bus.crd), 32'd1);
        chk("sr_caddr", 32'(bus.caddr_rd), 32'h041);
        chk("sr_csel", 32'(bus.csel), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("sr_rvalid", 32'(bus.rvalid), 32'h2);
        chk("sr_rdata", 32'(bus.rdata), 32'h0ABCD);
        repeat (3) step();

        // Locked burst on requester 2 while requester 0 waits
        set_rq(0, 1'b1, 1'b0, 1'b0, 3'b000, 12'd5, 20'h0);
        set_rq(2, 1'b1, 1'b0, 1'b1, 3'b010, lock_addr[0], 20'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lk_gnt", 32'(bus.gnt), 32'h4);
            if (k == 3) begin
                chk("lk_rv0", 32'(bus.rvalid), 32'h4);
                chk("lk_rd0", 32'(bus.rdata), 32'h5A000);
            end
            if (k == 4) chk("lk_rd1", 32'(bus.rdata), 32'h5A001);
            step();
            if (k < 3) set_rq(2, 1'b1, 1'b0, 1'b1, 3'b010, lock_addr[k+1], 20'h0);
            else if (k == 3) set_rq(2, 1'b1, 1'b1, 1'b0, 3'b011, 12'd0, 20'h77777);
            else bus.req[2] = 1'b0;
        end
        @(negedge clk);
        chk("lk_next_gnt", 32'(bus.gnt), 32'h1);
        chk("lk_cwr", 32'(bus.cwr), 32'd1);
        chk("lk_csel", 32'(bus.csel), 32'h3);
        step();
        bus.req = '0;
        repeat (4) step();

        // Read-after-write to the same address from different requesters
        set_rq(0, 1'b1, 1'b1, 1'b0, 3'b000, 12'd100, 20'h12345);
        @(negedge clk);
        chk("raw_wgnt", 32'(bus.gnt), 32'h1);
        step();
        bus.req[0] = 1'b0;
        set_rq(1, 1'b1, 1'b0, 1'b0, 3'b001, 12'd100, 20'h0);
        @(negedge clk);
        chk("raw_rgnt", 32'(bus.gnt), 32'h2);
        chk("raw_cwr", 32'(bus.cwr), 32'd1);
        step();
        bus.req = '0;
        @(negedge clk);
        chk("raw_crd", 32'(bus.crd), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("raw_rvalid", 32'(bus.rvalid), 32'h2);
        chk("raw_rdata", 32'(bus.rdata), 32'h12345);
        repeat (3) step();

        // Reset one cycle after a read grant
        set_rq(1, 1'b1, 1'b0, 1'b0, 3'b001, 12'd7, 20'h0);
        @(negedge clk);
        chk("rm_gnt", 32'(bus.gnt), 32'h2);
        step();
        reset   = 1'b1;
        bus.req = 3'b011;
        @(negedge clk);
        chk("rm_crd", 32'(bus.crd), 32'd0);
        chk("rm_gnt_rst", 32'(bus.gnt), 32'd0);
        chk("rm_busy", 32'(bus.busy), 32'd0);
        step();
        step();
        bus.req = '0;
        reset   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rm_no_rvalid", 32'(bus.rvalid), 32'd0);
        end
        step();
        bus.req = 3'b110;
        @(negedge clk);
        chk("rm_lowest", 32'(bus.gnt), 32'h2);
        step();
        bus.req = '0;
        repeat (4) step();

        // Idle port
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_gnt", 32'(bus.gnt), 32'd0);
            chk("idle_cmd", 32'({bus.cwr, bus.crd}), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end

        // Randomized traffic; a request holds its fields until granted
        repeat (3000) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!(bitof(32'(bus.req), i) && !bitof(32'(last_gnt), i)))
                    set_rq(i, ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 99) < 30), SW'($urandom), AW'($urandom_range(0, 15)),
                           DW'($urandom));
            end
        end
        step();
        bus.req = '0;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lmem_arbiter.md
Name: lmem_arbiter

Overview:
- Round-robin arbiter and sequencer for the single shared layer-memory port (csel / cwr / crd / caddr / cdata bus) that the convolution, max-pool and readback engines all use.
- Accepts one access per cycle from N requesters and drives registered memory commands.
- Returns read data to the requester that owns it, with a tag.
- Provides a lock so an engine can hold the port for a burst, for example four max-pool reads followed by one write.

Parameters:
N_REQ, 3, number of requesters (2..8)
AW, 12, memory address width
DW, 20, memory data width
SW, 3, csel width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester access request, held until granted
we  in  N_REQ  1 = write, 0 = read
lock  in  N_REQ  keep ownership after this grant
sel  in  N_REQ*SW  packed csel per requester (slice i = requester i)
addr  in  N_REQ*AW  packed address per requester
wdata  in  N_REQ*DW  packed write data per requester
gnt  out  N_REQ  one-hot grant (combinational)
rvalid  out  N_REQ  one-hot read-return strobe
rdata  out  DW  read-return data
csel  out  SW  memory select
cwr  out  1  memory write strobe
caddr_wr  out  AW  memory write address
cdata_wr  out  DW  memory write data
crd  out  1  memory read strobe
caddr_rd  out  AW  memory read address
cdata_rd  in  DW  memory read data, valid in the cycle after crd
busy  out  1  any request pending, any command issued or any read in flight

Behaviour:
- Reset values: all registered outputs 0; rr_ptr = 0; owner = none; read pipeline empty.
- The arbiter is combinational in cycle t:
  - If owner is valid and req[owner] is high, gnt = owner.
  - Otherwise gnt = first i with req[i], searching from rr_ptr upward with wrap-around.
  - gnt = 0 when no req is high.
- At most one gnt bit is set per cycle. A requester sees gnt[i] high, samples it at posedge, and may change its fields or drop req in the next cycle.
- On the posedge ending cycle t with gnt[i]:
  - Write: cwr = 1, caddr_wr = addr_i, cdata_wr = wdata_i, csel = sel_i, crd = 0, all valid in cycle t+1.
  - Read: crd = 1, caddr_rd = addr_i, csel = sel_i, cwr = 0, all valid in cycle t+1.
  - Idle cycle (no grant): cwr = crd = 0. csel, caddr and cdata hold their last values.
- cwr and crd are never high in the same cycle.
- Read return: cdata_rd is captured at the end of cycle t+2. rdata and rvalid[i] are high for exactly one cycle, t+3.
  - Total read latency is 3 cycles from grant.
  - The tag pipeline is 2 stages deep, so back-to-back reads from any mix of requesters return in grant order.
- rr_ptr update on a grant to i:
  - Without lock or hold: rr_ptr = (i+1) mod N_REQ.
  - rr_ptr does not move while owner holds the port.
- Lock:
  - A grant to i with lock[i] = 1 sets owner = i.
  - owner is cleared on a grant with lock[owner] = 0, or when req[owner] is low for a cycle.
  - While owner is valid, other requesters are not granted, even when the owner is idle.
  - Clearing owner on the owner's idle cycle bounds starvation.
- A write granted at t updates the memory at the end of t+1. A read of the same address granted at t+1 or later returns the new data.
- busy = |req, OR cwr, OR crd, OR any read-pipeline stage valid.
- Reset asserted mid-operation: in-flight reads are dropped, and no rvalid is issued after reset.
- An out-of-range requester index cannot occur. With N_REQ not a power of 2, rr_ptr wraps explicitly from N_REQ-1 to 0.

Test Plan:
- Single read: req[1], we = 0, sel = 3'b001, addr = 12'h041 at t = 2 → gnt[1] at t = 2; crd = 1 and caddr_rd = 12'h041 at t = 3; memory returns 20'h0ABCD; rvalid[1] = 1 and rdata = 20'h0ABCD at t = 5.
- Round-robin: req = 3'b111 held continuously from rr_ptr = 0 → gnt sequence 0, 1, 2, 0, 1, 2 on consecutive cycles, one memory command per cycle.
- Lock burst: req[2] with lock for 4 reads at addrs 0, 1, 64, 65, then an unlocked write with sel = 3'b011, addr = 0, while req[0] is held → req[0] is not granted until after the write; rvalid[2] fires 4 times in address order; req[0] is granted the cycle after the write grant.
- Read-after-write: requester 0 writes 20'h12345 to addr 100 at t, requester 1 reads addr 100 at t+1 → rvalid[1] at t+4 with rdata = 20'h12345; cwr and crd never high together.
- Reset mid-read: assert reset 1 cycle after a read grant → all outputs 0 immediately; no rvalid for the next 5 cycles after reset release; next grant goes to the lowest requesting index.
- Idle: no req for 10 cycles → gnt = 0, cwr = crd = 0, busy = 0.
